muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply-divide controller: drives an external multiplier and runs a
// 32-step restoring divider. Define MULDIV_EARLY_DIV0_EN to finish divide-by-zero in one cycle.
module muldiv_ctrl #(
  parameter int unsigned MULT_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_rs,
  input  logic [31:0] op_rt,
  output logic        op_ready,
  input  logic        cancel,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_stall,
  output logic        busy,
  output logic [32:0] mul_a,
  output logic [32:0] mul_b,
  input  logic [65:0] mul_p
);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  localparam logic [4:0] MulLast = 5'(MULT_LAT - 1);
  localparam logic [4:0] DivLast = 5'd31;

`ifdef MULDIV_EARLY_DIV0_EN
  localparam bit EarlyDiv0 = 1'b1;
`else
  localparam bit EarlyDiv0 = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StMulWait, StDivRun, StDivFix} state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [32:0] mul_a_q, mul_a_d;
  logic [32:0] mul_b_q, mul_b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  logic        accept;
  logic        is_signed;
  logic [31:0] dvd_abs;
  logic [31:0] dvs_abs;
  logic [32:0] rem_shift;
  logic [31:0] rem_sub;
  logic        rem_ge;
  logic        unused_mul_p;

  // Product is at most 64 significant bits; the top two are sign copies.
  assign unused_mul_p = ^mul_p[65:64];

  assign op_ready = (state_q == StIdle);
  assign busy     = ~op_ready;
  assign rd_stall = rd_req & busy;
  assign rd_data  = rd_sel ? hi_q : lo_q;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;

  assign accept    = op_valid & op_ready & ~cancel;
  assign is_signed = ~op_code[0];
  assign dvd_abs   = (is_signed && op_rs[31]) ? -op_rs : op_rs;
  assign dvs_abs   = (is_signed && op_rt[31]) ? -op_rt : op_rt;

  // Restoring step: the dividend shifts out of quo_q MSB-first as quotient bits shift in.
  assign rem_shift = {rem_q, quo_q[31]};
  assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
  assign rem_sub   = rem_shift[31:0] - dvs_q;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (op_code)
            OpMult, OpMultu: begin
              mul_a_d = {is_signed & op_rs[31], op_rs};
              mul_b_d = {is_signed & op_rt[31], op_rt};
              cnt_d   = '0;
              state_d = StMulWait;
            end
            OpDiv, OpDivu: begin
              quo_d     = dvd_abs;
              rem_d     = '0;
              dvs_d     = dvs_abs;
              neg_quo_d = is_signed & (op_rs[31] ^ op_rt[31]);
              neg_rem_d = is_signed & op_rs[31];
              cnt_d     = '0;
              state_d   = StDivRun;
              // Zero divisor: the full run would produce all-ones / dividend anyway.
              if (EarlyDiv0 && (op_rt == 32'd0)) begin
                quo_d   = '1;
                rem_d   = dvd_abs;
                state_d = StDivFix;
              end
            end
            OpMthi:  hi_d = op_rs;
            OpMtlo:  lo_d = op_rs;
            default: ;
          endcase
        end
      end
      StMulWait: begin
        if (cancel) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == MulLast) begin
          hi_d    = mul_p[63:32];
          lo_d    = mul_p[31:0];
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StDivRun: begin
        if (cancel) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          rem_d = rem_ge ? rem_sub : rem_shift[31:0];
          quo_d = {quo_q[30:0], rem_ge};
          if (cnt_q == DivLast) begin
            cnt_d   = '0;
            state_d = StDivFix;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StDivFix: begin
        if (!cancel) begin
          lo_d = neg_quo_q ? -quo_q : quo_q;
          hi_d = neg_rem_q ? -rem_q : rem_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      hi_q      <= '0;
      lo_q      <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule
